multicycle_controller: RTL and testbench

Main control unit for the RISC-V multicycle datapath. A Moore state machine sequences each instruction through fetch, decode, address/execute, memory and writeback. It drives every enable and mux select in the datapath: PC, IR, register file, memory, ALU source muxes, and the result mux that selects the ALUOut register among others. It also contains the combinational ALU decoder and immediate-select decoder.

---
 rtl/multicycle_controller_if.sv | 48 ++++
 rtl/multicycle_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Interface bundling the instruction fields, status flags and datapath
// controls exchanged between the multicycle controller and its datapath.
//
// Optional feature macro: MEM_WAIT_EN adds the mem_ready handshake line.
//
// Modports:
//   master - datapath side: drives instruction fields / flags, reads controls
//   slave  - controller side: reads instruction fields / flags, drives controls
interface multicycle_controller_if;
    // Instruction fields and datapath status
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
`ifdef MEM_WAIT_EN
    logic       mem_ready;
`endif
    // Datapath controls
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [3:0] state;

    modport master (
`ifdef MEM_WAIT_EN
        output mem_ready,
`endif
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write, state
    );

    modport slave (
`ifdef MEM_WAIT_EN
        input  mem_ready,
`endif
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_control, imm_src, reg_write, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control unit of the RISC-V multicycle datapath.
//
// A Moore FSM walks each instruction through fetch, decode, address/execute,
// memory and writeback, driving every enable and mux select of the datapath.
// It also holds the combinational ALU decoder and immediate-select decoder.
//
// Optional feature macro: MEM_WAIT_EN. When defined, FETCH, MEMREAD and
// MEMWRITE stall until bus.mem_ready is high, and the memory-side write
// enables of those states only fire in the cycle mem_ready is seen.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low; forces FETCH and blocks all writes
//   bus    - multicycle_controller_if.slave: op/funct3/funct7b5/zero
//            (+mem_ready) in; pc_write, adr_src, mem_write, ir_write,
//            result_src, alu_src_a, alu_src_b, alu_control, imm_src,
//            reg_write and the debug state code out.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.slave        bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state_r;
    state_t     state_next_s;
    alu_op_t    alu_op_s;
    logic       mem_ready_s;
    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_control_s;
    logic [1:0] imm_src_s;

`ifdef MEM_WAIT_EN
    assign mem_ready_s = bus.mem_ready;
`else
    // Without the handshake every memory access completes in one cycle.
    assign mem_ready_s = 1'b1;
`endif

    // State register; reset lands in FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:    state_next_s = mem_ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW:    state_next_s = S_MEMADR;
                    OP_SW:    state_next_s = S_MEMADR;
                    OP_RTYPE: state_next_s = S_EXECUTER;
                    OP_ITYPE: state_next_s = S_EXECUTEI;
                    OP_BEQ:   state_next_s = S_BEQ;
                    OP_JAL:   state_next_s = S_JAL;
                    default:  state_next_s = S_FETCH;  // unknown op: NOP
                endcase
            end
            S_MEMADR: begin
                case (bus.op)
                    OP_LW:   state_next_s = S_MEMREAD;
                    OP_SW:   state_next_s = S_MEMWRITE;
                    default: state_next_s = S_FETCH;
                endcase
            end
            S_MEMREAD:  state_next_s = mem_ready_s ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next_s = S_FETCH;
            S_MEMWRITE: state_next_s = mem_ready_s ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next_s = S_ALUWB;
            S_EXECUTEI: state_next_s = S_ALUWB;
            S_ALUWB:    state_next_s = S_FETCH;
            S_BEQ:      state_next_s = S_FETCH;
            S_JAL:      state_next_s = S_ALUWB;
            default:    state_next_s = S_FETCH;  // codes 11-15
        endcase
    end

    // Moore control outputs per state (BEQ also looks at zero).
    always_comb begin
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = ALU_OP_ADD;
        case (state_r)
            S_FETCH: begin
                // PC + 4 goes straight to PC via ALUResult.
                ir_write_s   = mem_ready_s;
                pc_write_s   = mem_ready_s;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
            end
            S_DECODE: begin
                // OldPC + imm: branch target parked in ALUOut.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = mem_ready_s;
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = ALU_OP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                // ALUOut still holds the target computed in DECODE.
                alu_src_a_s = 2'b10;
                alu_op_s    = ALU_OP_SUB;
                pc_write_s  = bus.zero;
            end
            S_JAL: begin
                // PC <- target from ALUOut; ALU forms OldPC + 4 for rd.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
            end
            default: begin
                alu_op_s = ALU_OP_ADD;
            end
        endcase
    end

    // ALU decoder.
    always_comb begin
        alu_control_s = 3'b000;
        case (alu_op_s)
            ALU_OP_ADD: alu_control_s = 3'b000;
            ALU_OP_SUB: alu_control_s = 3'b001;
            ALU_OP_FUNCT: begin
                case (bus.funct3)
                    // op[5] separates R-type sub from addi with imm[10] set.
                    3'b000:  alu_control_s = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_s = 3'b101;
                    3'b110:  alu_control_s = 3'b011;
                    3'b111:  alu_control_s = 3'b010;
                    default: alu_control_s = 3'b000;
                endcase
            end
            default: alu_control_s = 3'b000;
        endcase
    end

    // Immediate-format decoder, independent of state.
    always_comb begin
        imm_src_s = 2'b00;
        case (bus.op)
            OP_LW:    imm_src_s = 2'b00;
            OP_ITYPE: imm_src_s = 2'b00;
            OP_SW:    imm_src_s = 2'b01;
            OP_BEQ:   imm_src_s = 2'b10;
            OP_JAL:   imm_src_s = 2'b11;
            default:  imm_src_s = 2'b00;
        endcase
    end

    // Write enables are masked by the reset level itself so nothing is
    // written while reset is held, even in the FETCH state it forces.
    assign bus.pc_write    = pc_write_s  & reset;
    assign bus.ir_write    = ir_write_s  & reset;
    assign bus.mem_write   = mem_write_s & reset;
    assign bus.reg_write   = reg_write_s & reset;
    assign bus.adr_src     = adr_src_s;
    assign bus.result_src  = result_src_s;
    assign bus.alu_src_a   = alu_src_a_s;
    assign bus.alu_src_b   = alu_src_b_s;
    assign bus.alu_control = alu_control_s;
    assign bus.imm_src     = imm_src_s;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams checked against a per-instruction model
// (state path per opcode class and per-state control table).
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mr_random = 1'b0;
    int   mr_hold = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {state, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw}.
    function automatic logic [19:0] dut_vec();
        return {bus.state, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
                bus.imm_src, bus.reg_write};
    endfunction

    // ALU operation requested by an R/I-type instruction.
    function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'd0) return (o[5] && f7) ? 3'b001 : 3'b000;  // sub only for R-type
        else if (f3 == 3'd2) return 3'b101;                        // slt
        else if (f3 == 3'd6) return 3'b011;                        // or
        else if (f3 == 3'd7) return 3'b010;                        // and
        else return 3'b000;
    endfunction

    // Expected control vector for a state under given instruction fields.
    function automatic logic [19:0] model_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                              input logic f7, input logic z, input logic mr,
                                              input logic in_rst);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic [3:0] s4;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000; imm = 2'b00;
        case (st)
            0:  begin irw = mr; pcw = mr; sb = 2'b10; rs = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1'b1;
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = mr; end
            6:  begin sa = 2'b10; alu = funct_alu(o, f3, f7); end
            7:  begin sa = 2'b10; sb = 2'b01; alu = funct_alu(o, f3, f7); end
            8:  rw = 1'b1;
            9:  begin sa = 2'b10; alu = 3'b001; pcw = z; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        if (o == SW) imm = 2'b01;
        else if (o == BEQ) imm = 2'b10;
        else if (o == JAL) imm = 2'b11;
        else imm = 2'b00;
        if (in_rst) begin pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; end
        s4 = st[3:0];
        return {s4, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw};
    endfunction

    // Runs one instruction from FETCH to its last state, checking each cycle.
    // Entry/exit: just after a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        int path[$];
        int idx, guard, st;
        logic mr;
        logic [19:0] exp_v, act_v;
        case (o)
            LW:      path = '{0, 1, 2, 3, 4};
            SW:      path = '{0, 1, 2, 5};
            RT:      path = '{0, 1, 6, 8};
            IT:      path = '{0, 1, 7, 8};
            BEQ:     path = '{0, 1, 9};
            JAL:     path = '{0, 1, 10, 8};
            default: path = '{0, 1};
        endcase
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
        idx = 0; guard = 0;
        while (idx < path.size() && guard < 40) begin
            st = path[idx];
`ifdef MEM_WAIT_EN
            if (st == 5 && mr_hold > 0) begin mr = 1'b0; mr_hold--; end
            else if (mr_random) mr = ($urandom_range(0, 2) != 0);
            else mr = 1'b1;
            bus.mem_ready = mr;
`else
            mr = 1'b1;
`endif
            #1;
            exp_v = model_out(st, o, f3, f7, z, mr, 1'b0);
            act_v = dut_vec();
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL instr op=%b f3=%0d step=%0d: got %h, expected %h", o, f3, idx, act_v, exp_v);
            end
            @(negedge clk);
            if (!(st == 0 || st == 3 || st == 5) || mr) idx++;
            guard++;
        end
        vectors++;
        if (guard >= 40) begin
            miscompares++;
            $display("FAIL instr_timeout op=%b: stuck at step %0d, expected %0d steps", o, idx, path.size());
        end
    endtask

    task automatic test_reset();
        logic [19:0] exp_v;
        reset = 1'b0;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            exp_v = model_out(0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got %h, expected %h", i, dut_vec(), exp_v);
            end
        end
        reset = 1'b1;
        // Unknown op: FETCH (with its write pulse) then DECODE then FETCH.
        run_instr(7'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_lw();
        run_instr(LW, 3'd2, 1'b0, 1'b0);
        run_instr(LW, 3'd2, 1'b1, 1'b1);
    endtask

    task automatic test_alu_decode();
        run_instr(RT, 3'd0, 1'b1, 1'b0);  // sub
        run_instr(RT, 3'd0, 1'b0, 1'b0);  // add
        run_instr(RT, 3'd7, 1'b0, 1'b0);  // and
        run_instr(RT, 3'd2, 1'b0, 1'b0);  // slt
        run_instr(RT, 3'd6, 1'b0, 1'b0);  // or
        run_instr(IT, 3'd0, 1'b1, 1'b0);  // addi with imm bit set stays add
        run_instr(JAL, 3'd0, 1'b0, 1'b0);
        run_instr(SW, 3'd2, 1'b0, 1'b0);
    endtask

    task automatic test_beq();
        run_instr(BEQ, 3'd0, 1'b0, 1'b1);
        run_instr(BEQ, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_unknown();
        run_instr(7'b1111111, 3'd0, 1'b1, 1'b1);
        run_instr(7'b0000000, 3'd5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [19:0] exp_v;
        bus.op = LW; bus.funct3 = 3'd2; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        repeat (3) @(negedge clk);  // now in MEMREAD
        #1;
        vectors++;
        if (bus.state !== 4'd3) begin
            miscompares++;
            $display("FAIL abort_setup: state %0d, expected 3", bus.state);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            exp_v = model_out(0, LW, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
            vectors++;
            if (dut_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL reset_abort %0d: got %h, expected %h", i, dut_vec(), exp_v);
            end
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0] ops[6];
        logic [6:0] o;
        int k;
        ops = '{LW, SW, RT, IT, BEQ, JAL};
        mr_random = 1'b1;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 6);
            o = (k == 6) ? 7'($urandom_range(0, 127)) : ops[k];
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        mr_random = 1'b0;
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        mr_hold = 3;
        run_instr(SW, 3'd2, 1'b0, 1'b0);
        #1;
        vectors++;
        if (bus.state !== 4'd0) begin
            miscompares++;
            $display("FAIL mem_wait_exit: state %0d, expected 0", bus.state);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_alu_decode();
        test_beq();
        test_unknown();
        test_reset_abort();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
